// File: rtl/n_addsub.sv
// Mantissa add/subtract stage: two-deep valid/ready pipeline with full back-pressure.
// Optional NADD_LZC_EN adds a registered leading-zero count output LZ.
module n_addsub #(
  parameter int MW = 28,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          SA,
  input  logic          SB,
  input  logic [EW-1:0] EO,
  input  logic [MW-1:0] MA,
  input  logic [MW-1:0] MB,
  input  logic          Comp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          SO,
  output logic [EW-1:0] EOUT,
  output logic [MW:0]   MO,
  output logic          ZO,
`ifdef NADD_LZC_EN
  output logic [4:0]    LZ,
`endif
  output logic          CompO
);

  logic          s1_v_q, s1_v_d;
  logic          sa_q, sa_d;
  logic          sub_q, sub_d;
  logic [EW-1:0] eo_q, eo_d;
  logic [MW-1:0] ma_q, ma_d;
  logic [MW-1:0] mb_q, mb_d;
  logic          cmp_q, cmp_d;

  logic          s2_v_q, s2_v_d;
  logic          so_q, so_d;
  logic [EW-1:0] eout_q, eout_d;
  logic [MW:0]   mo_q, mo_d;
  logic          zo_q, zo_d;
  logic          cmpo_q, cmpo_d;
`ifdef NADD_LZC_EN
  logic [4:0]    lz_q, lz_d;
`endif

  logic          s1_en;
  logic          s2_en;
  logic [MW:0]   res;

`ifdef NADD_LZC_EN
  function automatic logic [4:0] lzc(input logic [MW-1:0] v);
    logic [4:0] n;
    logic        hit;
    n   = MW[4:0];
    hit = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!hit && v[i]) begin
        n   = 5'(MW - 1 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction
`endif

  // a stage loads when empty or when its occupant leaves this cycle
  assign s2_en    = !s2_v_q || out_ready;
  assign s1_en    = !s1_v_q || s2_en;
  assign in_ready = !rst && s1_en;

  always_comb begin
    if (sub_q) res = {1'b0, ma_q} - {1'b0, mb_q};
    else       res = {1'b0, ma_q} + {1'b0, mb_q};
  end

  always_comb begin
    s1_v_d = s1_v_q;
    sa_d   = sa_q;
    sub_d  = sub_q;
    eo_d   = eo_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    cmp_d  = cmp_q;
    if (s1_en) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        sa_d  = SA;
        sub_d = SA ^ SB;
        eo_d  = EO;
        ma_d  = MA;
        mb_d  = MB;
        cmp_d = Comp;
      end
    end
  end

  always_comb begin
    s2_v_d = s2_v_q;
    so_d   = so_q;
    eout_d = eout_q;
    mo_d   = mo_q;
    zo_d   = zo_q;
    cmpo_d = cmpo_q;
`ifdef NADD_LZC_EN
    lz_d   = lz_q;
`endif
    if (s2_en) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        mo_d   = res;
        zo_d   = (res == '0);
        so_d   = sa_q && (res != '0);
        eout_d = eo_q;
        cmpo_d = cmp_q;
`ifdef NADD_LZC_EN
        lz_d   = lzc(res[MW-1:0]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      sa_q   <= 1'b0;
      sub_q  <= 1'b0;
      eo_q   <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      cmp_q  <= 1'b0;
      s2_v_q <= 1'b0;
      so_q   <= 1'b0;
      eout_q <= '0;
      mo_q   <= '0;
      zo_q   <= 1'b0;
      cmpo_q <= 1'b0;
`ifdef NADD_LZC_EN
      lz_q   <= '0;
`endif
    end else begin
      s1_v_q <= s1_v_d;
      sa_q   <= sa_d;
      sub_q  <= sub_d;
      eo_q   <= eo_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      cmp_q  <= cmp_d;
      s2_v_q <= s2_v_d;
      so_q   <= so_d;
      eout_q <= eout_d;
      mo_q   <= mo_d;
      zo_q   <= zo_d;
      cmpo_q <= cmpo_d;
`ifdef NADD_LZC_EN
      lz_q   <= lz_d;
`endif
    end
  end

  assign out_valid = s2_v_q;
  assign SO        = so_q;
  assign EOUT      = eout_q;
  assign MO        = mo_q;
  assign ZO        = zo_q;
  assign CompO     = cmpo_q;
`ifdef NADD_LZC_EN
  assign LZ        = lz_q;
`endif

endmodule

// File: tb/tb_n_addsub.sv
// Directed bench for n_addsub: reset, add/sub vectors, back-pressure stream,
// reset with data in flight.
module tb_n_addsub;

  localparam int MW = 28;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          SA, SB, Comp;
  logic [EW-1:0] EO;
  logic [MW-1:0] MA, MB;
  logic          out_valid;
  logic          out_ready;
  logic          SO, ZO, CompO;
  logic [EW-1:0] EOUT;
  logic [MW:0]   MO;
`ifdef NADD_LZC_EN
  logic [4:0]    LZ;
`endif

  always #5 clk = ~clk;

  n_addsub #(.MW(MW), .EW(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .SA(SA), .SB(SB), .EO(EO), .MA(MA), .MB(MB), .Comp(Comp),
    .out_valid(out_valid), .out_ready(out_ready),
    .SO(SO), .EOUT(EOUT), .MO(MO), .ZO(ZO),
`ifdef NADD_LZC_EN
    .LZ(LZ),
`endif
    .CompO(CompO)
  );

  typedef struct packed {
    logic          so;
    logic [EW-1:0] eo;
    logic [MW:0]   mo;
    logic          zo;
    logic          cmp;
    logic [4:0]    lz;
  } res_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cnt   = 0;
  res_t exp_q[$];
  logic stall = 1'b0;
  logic [EW+MW+3:0] snap;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic sa, input logic sb,
                                 input logic [EW-1:0] eo,
                                 input logic [MW-1:0] ma,
                                 input logic [MW-1:0] mb,
                                 input logic cmp);
    res_t r;
    r.mo  = (sa ^ sb) ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, ma} + {1'b0, mb});
    r.zo  = (r.mo == 0);
    r.so  = r.zo ? 1'b0 : sa;
    r.eo  = eo;
    r.cmp = cmp;
    r.lz  = 5'(MW);
    for (int i = 0; i < MW; i++)
      if (r.mo[i]) r.lz = 5'(MW - 1 - i);
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    int   acc, emt;
    if (rst) begin
      exp_q.delete();
      cnt   = 0;
      stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(cnt == 2 && !out_ready));
      if (stall) begin
        chk("hold_v", out_valid, 1);
        chk("hold_data", {SO, EOUT, MO, ZO, CompO}, snap);
      end
      acc = (in_valid && in_ready) ? 1 : 0;
      emt = (out_valid && out_ready) ? 1 : 0;
      if (emt == 1) begin
        n_out++;
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("q_mo", MO, e.mo);
          chk("q_so", SO, e.so);
          chk("q_eout", EOUT, e.eo);
          chk("q_zo", ZO, e.zo);
          chk("q_comp", CompO, e.cmp);
`ifdef NADD_LZC_EN
          chk("q_lz", LZ, e.lz);
`endif
        end
      end
      if (acc == 1) exp_q.push_back(model(SA, SB, EO, MA, MB, Comp));
      cnt   = cnt + acc - emt;
      stall = out_valid && !out_ready;
      snap  = {SO, EOUT, MO, ZO, CompO};
    end
  end

  task automatic send(input logic sa, input logic sb, input logic [EW-1:0] eo,
                      input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                      input logic cmp);
    logic got = 1'b0;
    in_valid = 1'b1;
    SA = sa; SB = sb; EO = eo; MA = ma; MB = mb; Comp = cmp;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic run_dir(input string tag, input logic sa, input logic sb,
                         input logic [EW-1:0] eo, input logic [MW-1:0] ma,
                         input logic [MW-1:0] mb, input logic [MW:0] e_mo,
                         input logic e_so, input logic e_zo,
                         input logic [4:0] e_lz);
    send(sa, sb, eo, ma, mb, 1'b1);
    @(negedge clk);
    chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_lat2"}, out_valid, 1);
    chk({tag, "_mo"}, MO, e_mo);
    chk({tag, "_so"}, SO, e_so);
    chk({tag, "_zo"}, ZO, e_zo);
    chk({tag, "_eout"}, EOUT, eo);
    chk({tag, "_comp"}, CompO, 1);
`ifdef NADD_LZC_EN
    chk({tag, "_lz"}, LZ, e_lz);
`else
    if (e_lz > 5'd28) chk({tag, "_lzarg"}, e_lz, 0);
`endif
    @(posedge clk); #1;
  endtask

  logic [MW-1:0] t_ma [8];
  logic [MW-1:0] t_mb [8];
  logic          t_sa [8];
  logic          t_sb [8];

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    SA = 1'b1; SB = 1'b0; Comp = 1'b1;
    EO = 8'h55; MA = 28'h1234567; MB = 28'h0000123;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outs", {SO, EOUT, MO, ZO, CompO}, 0);
`ifdef NADD_LZC_EN
      chk("rst_lz", LZ, 0);
`endif
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    run_dir("add", 0, 0, 8'h80, 28'h8000000, 28'h8000000,
            29'h10000000, 0, 0, 5'd28);
    run_dir("subz", 1, 0, 8'h7F, 28'h4A00000, 28'h4A00000,
            29'h0, 0, 1, 5'd28);
    run_dir("sub", 1, 0, 8'h90, 28'h8000000, 28'h0000001,
            29'h07FFFFFF, 1, 0, 5'd1);
    run_dir("addn", 1, 1, 8'h01, 28'h0000003, 28'h0000001,
            29'h4, 1, 0, 5'd25);

    t_ma = '{28'hFFFFFFF, 28'h0800000, 28'h1000000, 28'h0000010,
             28'h7654321, 28'h0000001, 28'hABCDEF0, 28'h8000001};
    t_mb = '{28'h0000001, 28'h0800000, 28'h0FFFFFF, 28'h0000008,
             28'h0123456, 28'h0000000, 28'h0BCDEF0, 28'h0000002};
    t_sa = '{0, 1, 0, 1, 0, 1, 1, 0};
    t_sb = '{0, 0, 1, 1, 0, 0, 0, 1};
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(t_sa[i], t_sb[i], 8'(i * 17), t_ma[i], t_mb[i], 1'(i));
      end
      begin
        for (int c = 0; c < 400 && n_out < base + 8; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    chk("bp_count", n_out - base, 8);
    chk("bp_drained", exp_q.size(), 0);

    out_ready = 1'b0;
    send(0, 0, 8'h11, 28'h0000005, 28'h0000006, 0);
    send(1, 0, 8'h22, 28'h0000009, 28'h0000002, 1);
    base = n_out;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_idle", out_valid, 0);
    end
    chk("mid_rst_none", n_out - base, 0);
    @(posedge clk); #1;
    run_dir("post_rst", 0, 1, 8'hC3, 28'h0F00000, 28'h0000F00,
            29'h0EFF100, 0, 0, 5'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
